// File: rtl/gp_operand_fetch.sv
// Operand fetch stage between decode and execute: scoreboards pending register
// writes, stalls on RAW hazards, and latches bypassed operands for execute.
module gp_operand_fetch (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] rs_a,
    input  logic [1:0] rs_b,
    input  logic       use_b,
    input  logic [1:0] rd,
    input  logic       rd_en,
    input  logic [7:0] reg0,
    input  logic [7:0] reg1,
    input  logic [7:0] reg2,
    input  logic [7:0] reg3,
    input  logic [7:0] wb_data,
    input  logic       wb_load0,
    input  logic       wb_load1,
    input  logic       wb_load2,
    input  logic       wb_load3,
    input  logic       flush,
    output logic       op_valid,
    input  logic       op_ready,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [1:0] op_rd,
    output logic       op_rd_en,
    output logic [3:0] busy,
    output logic [7:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t     state_p0;
    state_t     state_next;

    logic [1:0] rs_a_p0;
    logic [1:0] rs_b_p0;
    logic       use_b_p0;
    logic [1:0] rd_p0;
    logic       rd_en_p0;

    logic [7:0] rf_view [4];
    logic [3:0] wr_hit;
    logic       hazard;
    logic       capture;
    logic       latch;
    logic       stall;
    logic       drop;
    logic [3:0] busy_next;
    logic [7:0] sel_a;
    logic [7:0] sel_b;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign rf_view[0] = reg0;
    assign rf_view[1] = reg1;
    assign rf_view[2] = reg2;
    assign rf_view[3] = reg3;

    // The register file only honours the lowest-index strobe.
    always_comb begin
        wr_hit = 4'b0000;
        if (wb_load0)      wr_hit = 4'b0001;
        else if (wb_load1) wr_hit = 4'b0010;
        else if (wb_load2) wr_hit = 4'b0100;
        else if (wb_load3) wr_hit = 4'b1000;
    end

    assign hazard = (busy[rs_a_p0] & ~wr_hit[rs_a_p0]) |
                    (use_b_p0 & busy[rs_b_p0] & ~wr_hit[rs_b_p0]);

    assign sel_a = wr_hit[rs_a_p0] ? wb_data : rf_view[rs_a_p0];
    assign sel_b = !use_b_p0 ? 8'h00 :
                   (wr_hit[rs_b_p0] ? wb_data : rf_view[rs_b_p0]);

    assign req_ready = (state_p0 == IDLE);
    assign op_valid  = (state_p0 == VALID);

    always_comb begin
        state_next = state_p0;
        capture    = 1'b0;
        latch      = 1'b0;
        stall      = 1'b0;
        drop       = 1'b0;
        case (state_p0)
            IDLE: begin
                if (req_valid && !flush) begin
                    capture    = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (hazard) begin
                    stall = 1'b1;
                end else begin
                    latch      = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (flush) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end else if (op_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new pending write on the same register outranks the retiring one.
    always_comb begin
        busy_next = busy & ~wr_hit;
        if (drop && op_rd_en) busy_next[op_rd] = 1'b0;
        if (latch && rd_en_p0) busy_next[rd_p0] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0  <= IDLE;
            rs_a_p0   <= 2'd0;
            rs_b_p0   <= 2'd0;
            use_b_p0  <= 1'b0;
            rd_p0     <= 2'd0;
            rd_en_p0  <= 1'b0;
            op_a      <= 8'h00;
            op_b      <= 8'h00;
            op_rd     <= 2'd0;
            op_rd_en  <= 1'b0;
            busy      <= 4'b0000;
            stall_cnt <= 8'h00;
        end else begin
            state_p0 <= state_next;
            busy     <= busy_next;
            if (capture) begin
                rs_a_p0  <= rs_a;
                rs_b_p0  <= rs_b;
                use_b_p0 <= use_b;
                rd_p0    <= rd;
                rd_en_p0 <= rd_en;
            end
            if (latch) begin
                op_a     <= sel_a;
                op_b     <= sel_b;
                op_rd    <= rd_p0;
                op_rd_en <= rd_en_p0;
            end
            if (stall) stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_gp_operand_fetch.sv
// Directed and randomized checks of gp_operand_fetch against a transaction-level model.
module tb_gp_operand_fetch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] rs_a = 2'd0;
    logic [1:0] rs_b = 2'd0;
    logic       use_b = 1'b0;
    logic [1:0] rd = 2'd0;
    logic       rd_en = 1'b0;
    logic [7:0] rf [4];
    logic [7:0] wb_data = 8'h00;
    logic [3:0] ld = 4'b0000;
    logic       flush = 1'b0;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] op_rd;
    logic       op_rd_en;
    logic [3:0] busy;
    logic [7:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Model: 0 = waiting for request, 1 = resolving hazards, 2 = holding operands.
    int         m_phase;
    logic [1:0] m_a, m_b, m_rd;
    logic       m_ub, m_rden;
    logic [7:0] m_op_a, m_op_b;
    logic [1:0] m_op_rd;
    logic       m_op_rden;
    logic       m_pending [4];
    int         m_stalls;

    always #5 clk = ~clk;

    gp_operand_fetch dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .rs_a(rs_a), .rs_b(rs_b), .use_b(use_b), .rd(rd), .rd_en(rd_en),
        .reg0(rf[0]), .reg1(rf[1]), .reg2(rf[2]), .reg3(rf[3]),
        .wb_data(wb_data), .wb_load0(ld[0]), .wb_load1(ld[1]), .wb_load2(ld[2]),
        .wb_load3(ld[3]), .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_rd_en(op_rd_en),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_a = 0; m_b = 0; m_rd = 0; m_ub = 0; m_rden = 0;
        m_op_a = 0; m_op_b = 0; m_op_rd = 0; m_op_rden = 0; m_stalls = 0;
        for (int i = 0; i < 4; i++) m_pending[i] = 1'b0;
    endtask

    function automatic logic [3:0] m_busy();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_pending[i];
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int  hit;
        bit  blocked;
        bit  pend_next [4];
        hit = -1;
        for (int i = 0; i < 4; i++) if (ld[i] && hit < 0) hit = i;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) pend_next[i] = m_pending[i];
        if (hit >= 0) pend_next[hit] = 1'b0;
        case (m_phase)
            0: if (req_valid && !flush) begin
                m_a = rs_a; m_b = rs_b; m_ub = use_b; m_rd = rd; m_rden = rd_en;
                m_phase = 1;
            end
            1: begin
                blocked = (m_pending[m_a] && hit != int'(m_a)) ||
                          (m_ub && m_pending[m_b] && hit != int'(m_b));
                if (flush) m_phase = 0;
                else if (blocked) begin
                    if (m_stalls < 255) m_stalls++;
                end else begin
                    m_op_a = (hit == int'(m_a)) ? wb_data : rf[m_a];
                    m_op_b = !m_ub ? 8'h00 : ((hit == int'(m_b)) ? wb_data : rf[m_b]);
                    m_op_rd = m_rd; m_op_rden = m_rden;
                    if (m_rden) pend_next[m_rd] = 1'b1;
                    m_phase = 2;
                end
            end
            default: begin
                if (flush) begin
                    if (m_op_rden) pend_next[m_op_rd] = 1'b0;
                    m_phase = 0;
                end else if (op_ready) m_phase = 0;
            end
        endcase
        for (int i = 0; i < 4; i++) m_pending[i] = pend_next[i];
        if (hit >= 0) rf[hit] = wb_data;
    endtask

    task automatic check_all();
        chk("req_ready", {7'd0, req_ready}, {7'd0, m_phase == 0});
        chk("op_valid", {7'd0, op_valid}, {7'd0, m_phase == 2});
        chk("op_a", op_a, m_op_a);
        chk("op_b", op_b, m_op_b);
        chk("op_rd", {6'd0, op_rd}, {6'd0, m_op_rd});
        chk("op_rd_en", {7'd0, op_rd_en}, {7'd0, m_op_rden});
        chk("busy", {4'd0, busy}, {4'd0, m_busy()});
        chk("stall_cnt", stall_cnt, 8'(m_stalls));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        req_valid = 0; flush = 0; op_ready = 0; ld = 4'b0000;
    endtask

    task automatic request(input logic [1:0] a, input logic [1:0] b, input logic ub,
                           input logic [1:0] d, input logic de);
        req_valid = 1; rs_a = a; rs_b = b; use_b = ub; rd = d; rd_en = de;
        cycle();
        req_valid = 0;
    endtask

    task automatic consume();
        op_ready = 1;
        cycle();
        op_ready = 0;
    endtask

    task automatic reset_now();
        reset = 1'b1;
        #2;
        chk("rst_req_ready", {7'd0, req_ready}, 8'd1);
        chk("rst_op_valid", {7'd0, op_valid}, 8'd0);
        chk("rst_op_a", op_a, 8'h00);
        chk("rst_op_b", op_b, 8'h00);
        chk("rst_op_rd", {6'd0, op_rd}, 8'd0);
        chk("rst_op_rd_en", {7'd0, op_rd_en}, 8'd0);
        chk("rst_busy", {4'd0, busy}, 8'd0);
        chk("rst_stall_cnt", stall_cnt, 8'd0);
        model_reset();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        model_reset();
        #1;
        reset_now();

        // Basic fetch with two sources.
        rf[1] = 8'h12; rf[2] = 8'h34;
        request(2'd1, 2'd2, 1'b1, 2'd3, 1'b1);
        cycle();
        chk("basic_op_a", op_a, 8'h12);
        chk("basic_op_b", op_b, 8'h34);
        chk("basic_busy", {4'd0, busy}, 8'h08);
        consume();

        // Read-after-write on r3 resolved by a bypassed write-back.
        request(2'd3, 2'd0, 1'b0, 2'd0, 1'b0);
        cycle();
        cycle();
        chk("raw_stall_cnt", stall_cnt, 8'd2);
        ld = 4'b1000; wb_data = 8'hA5;
        cycle();
        ld = 4'b0000;
        chk("raw_op_a", op_a, 8'hA5);
        chk("raw_busy", {4'd0, busy}, 8'h00);
        consume();

        // Simultaneous strobes: only r0 is written, r2 stays pending.
        request(2'd0, 2'd0, 1'b0, 2'd2, 1'b1); cycle(); consume();
        request(2'd1, 2'd0, 1'b0, 2'd0, 1'b1); cycle(); consume();
        request(2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
        ld = 4'b0101; wb_data = 8'h77;
        cycle();
        ld = 4'b0000;
        chk("prio_busy", {4'd0, busy}, 8'h04);
        chk("prio_op_valid", {7'd0, op_valid}, 8'd0);
        ld = 4'b0100; wb_data = 8'h3C;
        cycle();
        ld = 4'b0000;
        chk("prio_op_a", op_a, 8'h3C);
        consume();

        // use_b=0 ignores a pending rs_b; then flush from VALID releases op_rd.
        request(2'd0, 2'd0, 1'b0, 2'd1, 1'b1); cycle(); consume();
        request(2'd0, 2'd1, 1'b0, 2'd1, 1'b1);
        cycle();
        chk("nob_op_valid", {7'd0, op_valid}, 8'd1);
        chk("nob_op_b", op_b, 8'h00);
        flush = 1;
        cycle();
        flush = 0;
        chk("flushv_op_valid", {7'd0, op_valid}, 8'd0);
        chk("flushv_busy", {4'd0, busy}, 8'h00);

        // Flush during a stall leaves the scoreboard alone.
        request(2'd0, 2'd0, 1'b0, 2'd3, 1'b1); cycle(); consume();
        request(2'd3, 2'd0, 1'b0, 2'd0, 1'b0);
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        chk("flushc_ready", {7'd0, req_ready}, 8'd1);
        chk("flushc_busy", {4'd0, busy}, 8'h08);
        ld = 4'b1000; wb_data = 8'h5A;
        cycle();
        quiet();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            req_valid = $urandom_range(0, 1);
            rs_a = 2'($urandom); rs_b = 2'($urandom); use_b = $urandom_range(0, 1);
            rd = 2'($urandom); rd_en = $urandom_range(0, 1);
            ld = 4'($urandom & $urandom);
            wb_data = 8'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            op_ready = $urandom_range(0, 1);
            cycle();
        end
        quiet();

        // Async reset in the middle of a stall with stall_cnt at 7.
        #1;
        reset_now();
        request(2'd0, 2'd0, 1'b0, 2'd0, 1'b1); cycle(); consume();
        request(2'd0, 2'd0, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 7; i++) cycle();
        chk("pre_rst_stall", stall_cnt, 8'd7);
        #1;
        reset_now();

        // Saturation of the stall counter.
        request(2'd2, 2'd0, 1'b0, 2'd2, 1'b1); cycle(); consume();
        request(2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 300; i++) cycle();
        chk("sat_stall_cnt", stall_cnt, 8'd255);
        flush = 1;
        cycle();
        flush = 0;
        chk("sat_hold", stall_cnt, 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
